// File: rtl/light_conflict_monitor.sv
// light_conflict_monitor
//
// Independent safety monitor for the intersection's NS/EW 7-segment light
// buses. Each bus is registered, decoded to a colour code, and passed
// through a glitch filter. The accepted colours are then checked for unsafe
// combinations and transitions. The first detected cause is latched as a
// fault that drives the controller's error input.
//
// Colour codes: RED=0 YELLOW=1 GREEN=2 ERRSEG=3 OFF=4 UNKNOWN=7
// Fault codes : CONFLICT=1 SKIP_YELLOW=2 SHORT_YELLOW=3 UNKNOWN=4 WATCHDOG=5
//
// Ports:
//   clk          system clock (same domain as the controller)
//   reset        asynchronous, active-high reset
//   ns_light     NS segment bus from the controller
//   ew_light     EW segment bus from the controller
//   clear_fault  synchronous pulse, clears the latched fault
//   ns_color     accepted NS colour code
//   ew_color     accepted EW colour code
//   fault        latched fault (to the controller's error input)
//   fault_code   cause of the first fault since the last clear
//   fault_count  (only with FAULT_COUNT_EN) number of fault assertions,
//                saturating at 255, cleared only by reset
//
// Optional feature macro: FAULT_COUNT_EN
module light_conflict_monitor #(
  parameter int unsigned GLITCH_CYCLES     = 4,
  parameter int unsigned MIN_YELLOW_CYCLES = 90_000_000,
  parameter int unsigned WATCHDOG_CYCLES   = 1_000_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] ns_light,
  input  logic [7:0] ew_light,
  input  logic       clear_fault,
  output logic [2:0] ns_color,
  output logic [2:0] ew_color,
  output logic       fault,
  output logic [2:0] fault_code
`ifdef FAULT_COUNT_EN
  ,
  output logic [7:0] fault_count
`endif
);

  localparam logic [2:0] C_RED = 3'd0;
  localparam logic [2:0] C_YEL = 3'd1;
  localparam logic [2:0] C_GRN = 3'd2;
  localparam logic [2:0] C_ERR = 3'd3;
  localparam logic [2:0] C_OFF = 3'd4;
  localparam logic [2:0] C_UNK = 3'd7;

  localparam logic [7:0]  GLITCH_C = 8'(GLITCH_CYCLES);
  localparam logic [31:0] MIN_Y_C  = MIN_YELLOW_CYCLES;
  localparam logic [31:0] WD_C     = WATCHDOG_CYCLES;

  function automatic logic [2:0] decode(input logic [7:0] seg);
    case (seg)
      8'b10001000: return C_RED;
      8'b10011001: return C_YEL;
      8'b10000010: return C_GRN;
      8'b10000000: return C_ERR;
      8'b11111111: return C_OFF;
      default:     return C_UNK;
    endcase
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v, input logic [31:0] lim);
    return (v >= lim) ? lim : v + 32'd1;
  endfunction

  function automatic logic is_go(input logic [2:0] c);
    return (c == C_YEL) || (c == C_GRN);
  endfunction

  function automatic logic is_lit(input logic [2:0] c);
    return (c == C_RED) || (c == C_YEL) || (c == C_GRN);
  endfunction

  // ---- stage p0: bus capture ----
  // Data-only register: it keeps sampling through reset, so a bus that is
  // steady across reset is reacquired GLITCH_CYCLES edges after release.
  logic [7:0] ns_bus_p0, ew_bus_p0;

  always_ff @(posedge clk) begin
    ns_bus_p0 <= ns_light;
    ew_bus_p0 <= ew_light;
  end

  // ---- stage p1: decode and glitch filter ----
  logic [2:0] ns_dec, ew_dec;
  logic [2:0] ns_cand_p1, ew_cand_p1;
  logic [7:0] ns_run_p1, ew_run_p1;
  logic [7:0] ns_run_nxt, ew_run_nxt;

  assign ns_dec = decode(ns_bus_p0);
  assign ew_dec = decode(ew_bus_p0);

  always_comb begin
    ns_run_nxt = (ns_dec == ns_cand_p1) ? sat_inc8(ns_run_p1) : 8'd1;
    ew_run_nxt = (ew_dec == ew_cand_p1) ? sat_inc8(ew_run_p1) : 8'd1;
  end

  // The candidate always follows the decoded bus; only the run length
  // decides whether it is promoted to the accepted colour.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ns_cand_p1 <= C_OFF;
      ew_cand_p1 <= C_OFF;
      ns_run_p1  <= 8'd0;
      ew_run_p1  <= 8'd0;
      ns_color   <= C_OFF;
      ew_color   <= C_OFF;
    end else begin
      ns_cand_p1 <= ns_dec;
      ew_cand_p1 <= ew_dec;
      ns_run_p1  <= ns_run_nxt;
      ew_run_p1  <= ew_run_nxt;
      if (ns_run_nxt >= GLITCH_C) ns_color <= ns_dec;
      if (ew_run_nxt >= GLITCH_C) ew_color <= ew_dec;
    end
  end

  // ---- stage p2: history, duration counters and checks ----
  logic [2:0]  ns_prev_p2, ew_prev_p2;
  logic [31:0] ns_ycnt_p2, ew_ycnt_p2;
  logic [31:0] wd_cnt_p2;
  logic        changed, all_lit;
  logic        det_conflict, det_skip, det_short, det_unk, det_wd, det_any;
  logic [2:0]  det_code;

  assign changed = (ns_color != ns_prev_p2) || (ew_color != ew_prev_p2);
  assign all_lit = is_lit(ns_color) && is_lit(ew_color);

  always_comb begin
    det_conflict = is_go(ns_color) && is_go(ew_color);
    det_skip     = ((ns_prev_p2 == C_GRN) && (ns_color == C_RED)) ||
                   ((ew_prev_p2 == C_GRN) && (ew_color == C_RED));
    det_short    = ((ns_prev_p2 == C_YEL) && (ns_color == C_RED) && (ns_ycnt_p2 < MIN_Y_C)) ||
                   ((ew_prev_p2 == C_YEL) && (ew_color == C_RED) && (ew_ycnt_p2 < MIN_Y_C));
    det_unk      = (ns_color == C_UNK) || (ew_color == C_UNK);
    // Fires only on the step that reaches the limit; the counter then parks
    // at WATCHDOG_CYCLES so a clear is not immediately overridden.
    det_wd       = all_lit && !changed && (wd_cnt_p2 == WD_C - 32'd1);
    det_any      = det_conflict || det_skip || det_short || det_unk || det_wd;
    det_code     = 3'd0;
    if      (det_conflict) det_code = 3'd1;
    else if (det_skip)     det_code = 3'd2;
    else if (det_short)    det_code = 3'd3;
    else if (det_unk)      det_code = 3'd4;
    else if (det_wd)       det_code = 3'd5;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ns_prev_p2 <= C_OFF;
      ew_prev_p2 <= C_OFF;
      ns_ycnt_p2 <= 32'd0;
      ew_ycnt_p2 <= 32'd0;
      wd_cnt_p2  <= 32'd0;
    end else begin
      ns_prev_p2 <= ns_color;
      ew_prev_p2 <= ew_color;
      // Yellow time counts edges with YELLOW accepted; any other colour
      // (including OFF while flashing) restarts it.
      ns_ycnt_p2 <= (clear_fault || ns_color != C_YEL) ? 32'd0 : sat_inc32(ns_ycnt_p2, MIN_Y_C);
      ew_ycnt_p2 <= (clear_fault || ew_color != C_YEL) ? 32'd0 : sat_inc32(ew_ycnt_p2, MIN_Y_C);
      wd_cnt_p2  <= (clear_fault || changed || !all_lit) ? 32'd0 : sat_inc32(wd_cnt_p2, WD_C);
    end
  end

  // ---- fault latch ----
  // A detection wins over a simultaneous clear; otherwise the first cause
  // is held until cleared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fault      <= 1'b0;
      fault_code <= 3'd0;
    end else if (det_any && (clear_fault || !fault)) begin
      fault      <= 1'b1;
      fault_code <= det_code;
    end else if (clear_fault) begin
      fault      <= 1'b0;
      fault_code <= 3'd0;
    end
  end

`ifdef FAULT_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fault_count <= 8'd0;
    end else if (det_any && !fault) begin
      fault_count <= sat_inc8(fault_count);
    end
  end
`endif

endmodule

// File: tb/tb_light_conflict_monitor.sv
module tb_light_conflict_monitor;
  localparam int G    = 4;
  localparam int MINY = 20;
  localparam int WD   = 100;
  localparam int HN   = 4096;

  localparam logic [7:0] SR = 8'h88;
  localparam logic [7:0] SY = 8'h99;
  localparam logic [7:0] SG = 8'h82;
  localparam logic [7:0] SE = 8'h80;
  localparam logic [7:0] SO = 8'hFF;
  localparam logic [7:0] SU = 8'h00;

  logic       clk = 1'b0;
  logic       reset;
  logic       clear_fault;
  logic [7:0] ns_light, ew_light;
  logic [2:0] ns_color, ew_color, fault_code;
  logic       fault;
`ifdef FAULT_COUNT_EN
  logic [7:0] fault_count;
`endif

  int checks   = 0;
  int failures = 0;

  light_conflict_monitor #(
    .GLITCH_CYCLES(G),
    .MIN_YELLOW_CYCLES(MINY),
    .WATCHDOG_CYCLES(WD)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ns_light(ns_light),
    .ew_light(ew_light),
    .clear_fault(clear_fault),
    .ns_color(ns_color),
    .ew_color(ew_color),
    .fault(fault),
    .fault_code(fault_code)
`ifdef FAULT_COUNT_EN
    ,
    .fault_count(fault_count)
`endif
  );

  always #5 clk = ~clk;

  wire [9:0] obs = {ns_color, ew_color, fault, fault_code};

  // ---------------- reference model ----------------
  // Histories indexed by edge number since reset release (edge 0 = reset).
  // kns/kew: decoded value captured from the bus at each edge.
  // cns/cew: accepted colour after each edge. clr_h: clear at each edge.
  int e;
  int kns[HN], kew[HN], cns[HN], cew[HN];
  bit clr_h[HN];
  int m_fault, m_code, m_cnt;

  function automatic int dec(input logic [7:0] s);
    case (s)
      8'h88: return 0;
      8'h99: return 1;
      8'h82: return 2;
      8'h80: return 3;
      8'hFF: return 4;
      default: return 7;
    endcase
  endfunction

  function automatic bit lit(input int c);
    return c <= 2;
  endfunction

  function automatic bit go(input int c);
    return c == 1 || c == 2;
  endfunction

  function automatic int colr(input bit side, input int j);
    if (j < 0) return 4;
    return side ? cew[j] : cns[j];
  endfunction

  function automatic bit changed_at(input int j);
    return j >= 1 && (cns[j] != cns[j-1] || cew[j] != cew[j-1]);
  endfunction

  // Edges of uninterrupted accepted yellow ending at edge k (since any clear).
  function automatic int ylen(input bit side, input int k);
    int n = 0;
    int m = k;
    while (m >= 1 && n < MINY) begin
      if (colr(side, m-1) != 1 || clr_h[m]) break;
      n++;
      m--;
    end
    return n;
  endfunction

  // Edges ending at k with both sides lit, no accepted change, no clear.
  function automatic int idle(input int k);
    int n = 0;
    int m = k;
    while (m >= 1 && n < WD) begin
      if (clr_h[m] || !lit(cns[m-1]) || !lit(cew[m-1]) || changed_at(m-1)) break;
      n++;
      m--;
    end
    return n;
  endfunction

  task automatic model_reset(input logic [7:0] ns_cap, input logic [7:0] ew_cap);
    e = 0;
    kns[0] = dec(ns_cap);
    kew[0] = dec(ew_cap);
    cns[0] = 4;
    cew[0] = 4;
    clr_h[0] = 1'b0;
    m_fault = 0;
    m_code = 0;
    m_cnt = 0;
  endtask

  task automatic model_step();
    int a, b, pa, pb, det;
    bit same_n, same_e;
    e++;
    kns[e] = dec(ns_light);
    kew[e] = dec(ew_light);
    clr_h[e] = clear_fault;
    cns[e] = cns[e-1];
    cew[e] = cew[e-1];
    // A colour is accepted once the last G captures all agree.
    if (e >= G) begin
      same_n = 1'b1;
      same_e = 1'b1;
      for (int i = e - G + 1; i <= e - 1; i++) begin
        if (kns[i] != kns[e-G]) same_n = 1'b0;
        if (kew[i] != kew[e-G]) same_e = 1'b0;
      end
      if (same_n) cns[e] = kns[e-G];
      if (same_e) cew[e] = kew[e-G];
    end
    a  = colr(0, e-1);
    b  = colr(1, e-1);
    pa = colr(0, e-2);
    pb = colr(1, e-2);
    det = 0;
    if (go(a) && go(b)) det = 1;
    else if ((pa == 2 && a == 0) || (pb == 2 && b == 0)) det = 2;
    else if ((pa == 1 && a == 0 && ylen(0, e-1) < MINY) ||
             (pb == 1 && b == 0 && ylen(1, e-1) < MINY)) det = 3;
    else if (a == 7 || b == 7) det = 4;
    else if (lit(a) && lit(b) && !changed_at(e-1) && idle(e-1) == WD - 1) det = 5;
    if (det != 0 && (clear_fault || m_fault == 0)) begin
      if (m_fault == 0 && m_cnt < 255) m_cnt++;
      m_fault = 1;
      m_code = det;
    end else if (clear_fault) begin
      m_fault = 0;
      m_code = 0;
    end
  endtask

  function automatic logic [9:0] exp_vec();
    return {3'(cns[e]), 3'(cew[e]), 1'(m_fault), 3'(m_code)};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    ns_light = SO;
    ew_light = SO;
    clear_fault = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset(SO, SO);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    checks++;
    if (obs !== 10'b100_100_0_000) begin
      failures++;
      $display("FAIL reset_state got=%h want=%h", obs, 10'b100_100_0_000);
    end
`ifdef FAULT_COUNT_EN
    checks++;
    if (fault_count !== 8'd0) begin
      failures++;
      $display("FAIL reset_count got=%0d want=0", fault_count);
    end
`endif
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL reset_idle cyc=%0d got=%h want=%h", c, obs, exp_vec());
      end
    end
  endtask

  task automatic test_legal_cycle();
    logic [7:0] tn[], te[];
    int tl[];
    tn = '{SG, SY, SR, SR, SG};
    te = '{SR, SR, SG, SY, SR};
    tl = '{50, 25, 50, 25, 10};
    do_reset();
    for (int s = 0; s < tn.size(); s++) begin
      ns_light = tn[s];
      ew_light = te[s];
      for (int c = 0; c < tl[s]; c++) begin
        tick();
        checks++;
        if (obs !== exp_vec()) begin
          failures++;
          $display("FAIL legal_cycle seg=%0d cyc=%0d got=%h want=%h", s, c, obs, exp_vec());
        end
      end
    end
    checks++;
    if (fault !== 1'b0) begin
      failures++;
      $display("FAIL legal_no_fault got=%b want=0", fault);
    end
  endtask

  task automatic test_glitch();
    logic [7:0] te[];
    int tl[];
    te = '{SR, SG, SR, SG, SR};
    tl = '{10, 3, 12, 4, 6};
    do_reset();
    ns_light = SG;
    for (int s = 0; s < te.size(); s++) begin
      ew_light = te[s];
      for (int c = 0; c < tl[s]; c++) begin
        tick();
        checks++;
        if (obs !== exp_vec()) begin
          failures++;
          $display("FAIL glitch seg=%0d cyc=%0d got=%h want=%h", s, c, obs, exp_vec());
        end
      end
      if (s == 2) begin
        checks++;
        if ({ew_color, fault} !== 4'b000_0) begin
          failures++;
          $display("FAIL glitch_reject got=%b want=0000", {ew_color, fault});
        end
      end
    end
    checks++;
    if ({fault, fault_code} !== 4'b1_001) begin
      failures++;
      $display("FAIL glitch_conflict got=%b want=1001", {fault, fault_code});
    end
  endtask

  task automatic test_skip_short();
    logic [7:0] tn[];
    logic       tc[];
    int tl[];
    tn = '{SG, SR, SR, SR, SG, SY, SR};
    tc = '{0, 0, 1, 0, 0, 0, 0};
    tl = '{10, 8, 1, 3, 10, 10, 8};
    do_reset();
    ew_light = SR;
    for (int s = 0; s < tn.size(); s++) begin
      ns_light = tn[s];
      clear_fault = tc[s];
      for (int c = 0; c < tl[s]; c++) begin
        tick();
        checks++;
        if (obs !== exp_vec()) begin
          failures++;
          $display("FAIL skip_short seg=%0d cyc=%0d got=%h want=%h", s, c, obs, exp_vec());
        end
      end
      clear_fault = 1'b0;
      if (s == 1) begin
        checks++;
        if ({fault, fault_code} !== 4'b1_010) begin
          failures++;
          $display("FAIL skip_yellow got=%b want=1010", {fault, fault_code});
        end
      end
      if (s == 3) begin
        checks++;
        if (fault !== 1'b0) begin
          failures++;
          $display("FAIL skip_cleared got=%b want=0", fault);
        end
      end
    end
    checks++;
    if ({fault, fault_code} !== 4'b1_011) begin
      failures++;
      $display("FAIL short_yellow got=%b want=1011", {fault, fault_code});
    end
  endtask

  task automatic test_unknown_priority();
    logic [7:0] tn[], te[];
    int tl[];
    logic [3:0] want[3];
    want = '{4'b1_100, 4'b1_010, 4'b1_001};
    for (int v = 0; v < 3; v++) begin
      case (v)
        0: begin tn = '{SR, SU, SU}; te = '{SR, SR, SG}; tl = '{8, 8, 8}; end
        1: begin tn = '{SR, SU};     te = '{SG, SR};     tl = '{8, 8};    end
        default: begin tn = '{SR, SG}; te = '{SR, SY};   tl = '{8, 8};    end
      endcase
      do_reset();
      for (int s = 0; s < tn.size(); s++) begin
        ns_light = tn[s];
        ew_light = te[s];
        for (int c = 0; c < tl[s]; c++) begin
          tick();
          checks++;
          if (obs !== exp_vec()) begin
            failures++;
            $display("FAIL unk_prio v=%0d seg=%0d cyc=%0d got=%h want=%h", v, s, c, obs, exp_vec());
          end
        end
      end
      checks++;
      if ({fault, fault_code} !== want[v]) begin
        failures++;
        $display("FAIL unk_prio_code v=%0d got=%b want=%b", v, {fault, fault_code}, want[v]);
      end
    end
  endtask

  task automatic test_watchdog_clear();
    do_reset();
    ns_light = SG;
    ew_light = SR;
    for (int c = 0; c < 110; c++) begin
      tick();
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL watchdog cyc=%0d got=%h want=%h", c, obs, exp_vec());
      end
    end
    checks++;
    if ({fault, fault_code} !== 4'b1_101) begin
      failures++;
      $display("FAIL watchdog_code got=%b want=1101", {fault, fault_code});
    end
    clear_fault = 1'b1;
    tick();
    clear_fault = 1'b0;
    checks++;
    if ({fault, fault_code} !== 4'b0_000) begin
      failures++;
      $display("FAIL watchdog_clear got=%b want=0000", {fault, fault_code});
    end
    for (int c = 0; c < 100; c++) begin
      tick();
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL watchdog_refault cyc=%0d got=%h want=%h", c, obs, exp_vec());
      end
    end
    checks++;
    if ({fault, fault_code} !== 4'b1_101) begin
      failures++;
      $display("FAIL watchdog_again got=%b want=1101", {fault, fault_code});
    end
`ifdef FAULT_COUNT_EN
    checks++;
    if (fault_count !== 8'd2) begin
      failures++;
      $display("FAIL fault_count got=%0d want=2", fault_count);
    end
`endif
  endtask

  task automatic test_reset_mid_yellow();
    do_reset();
    ew_light = SR;
    ns_light = SG;
    for (int c = 0; c < 15; c++) begin
      if (c == 10) ns_light = SY;
      tick();
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL mid_yellow_pre cyc=%0d got=%h want=%h", c, obs, exp_vec());
      end
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (obs !== 10'b100_100_0_000) begin
      failures++;
      $display("FAIL async_reset got=%h want=%h", obs, 10'b100_100_0_000);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset(SY, SR);
    for (int c = 1; c <= 30; c++) begin
      tick();
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL mid_yellow_post cyc=%0d got=%h want=%h", c, obs, exp_vec());
      end
      if (c == 3 || c == 4) begin
        checks++;
        if (ns_color !== ((c == 4) ? 3'd1 : 3'd4)) begin
          failures++;
          $display("FAIL reacquire edge=%0d got=%0d want=%0d", c, ns_color, (c == 4) ? 1 : 4);
        end
      end
    end
    checks++;
    if (fault !== 1'b0) begin
      failures++;
      $display("FAIL mid_yellow_fault got=%b want=0", fault);
    end
  endtask

  task automatic test_random();
    logic [7:0] pool[6];
    int len;
    pool = '{SR, SY, SG, SE, SO, SU};
    do_reset();
    for (int s = 0; s < 150; s++) begin
      ns_light = pool[$urandom_range(0, 5)];
      ew_light = pool[$urandom_range(0, 5)];
      len = $urandom_range(1, 8);
      for (int c = 0; c < len; c++) begin
        clear_fault = ($urandom_range(0, 9) == 0);
        tick();
        checks++;
        if (obs !== exp_vec()) begin
          failures++;
          $display("FAIL random seg=%0d cyc=%0d got=%h want=%h", s, c, obs, exp_vec());
        end
`ifdef FAULT_COUNT_EN
        checks++;
        if (fault_count !== 8'(m_cnt)) begin
          failures++;
          $display("FAIL random_count seg=%0d got=%0d want=%0d", s, fault_count, m_cnt);
        end
`endif
      end
    end
    clear_fault = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    clear_fault = 1'b0;
    ns_light = SO;
    ew_light = SO;
    test_reset();
    test_legal_cycle();
    test_glitch();
    test_skip_short();
    test_unknown_priority();
    test_watchdog_clear();
    test_reset_mid_yellow();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "simulation time limit reached");
  end

endmodule
